// File: rtl/mem_read_arbiter_pkg.sv
// Shared types for the memory read arbiter: FSM states, burst owner, address/data words.
package mem_read_arbiter_pkg;

  localparam int LEN_W_DEF = 4;

  typedef logic [31:0] phys_t;
  typedef logic [31:0] uint32_t;
  typedef logic [LEN_W_DEF-1:0] burst_len_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_read_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester not served last wins; combinational.
module rr_arb2
  import mem_read_arbiter_pkg::*;
(
  input  logic   req_ic,
  input  logic   req_dc,
  input  owner_t last_owner,
  output logic   any_req,
  output owner_t winner
);

  assign any_req = req_ic | req_dc;

  always_comb begin
    winner = OWN_IC;
    if (req_ic && req_dc) begin
      winner = (last_owner == OWN_IC) ? OWN_DC : OWN_IC;
    end else if (req_dc) begin
      winner = OWN_DC;
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one burst read port between icache and dcache, one burst in flight; address phase
// is registered, read beats forward with zero latency and cannot be back-pressured.
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ic_req,
  input  phys_t            ic_addr,
  input  logic [LEN_W-1:0] ic_len,
  input  logic             ic_cancel,
  output logic             ic_gnt,
  output logic             ic_rvalid,
  input  logic             dc_req,
  input  phys_t            dc_addr,
  input  logic [LEN_W-1:0] dc_len,
  output logic             dc_gnt,
  output logic             dc_rvalid,
  output uint32_t          resp_rdata,
  output logic             resp_rlast,
  output logic             mem_arvalid,
  output phys_t            mem_araddr,
  output logic [LEN_W-1:0] mem_arlen,
  input  logic             mem_arready,
  input  logic             mem_rvalid,
  input  uint32_t          mem_rdata,
  input  logic             mem_rlast
);

  arb_state_t       state;
  owner_t           owner;
  owner_t           last_owner;
  owner_t           winner;
  logic             any_req;
  phys_t            addr_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic             arvalid_q;
  logic             cancel_q;
  logic             proto_err;
  logic             beat;
  logic             ic_own;
  logic             ic_dropping;

  rr_arb2 u_rr_arb2 (
    .req_ic     (ic_req),
    .req_dc     (dc_req),
    .last_owner (last_owner),
    .any_req    (any_req),
    .winner     (winner)
  );

  assign beat        = (state == DATA) && mem_rvalid;
  assign ic_own      = (owner == OWN_IC);
  // A flush drops the beat in the same cycle it is signalled, not just later ones.
  assign ic_dropping = cancel_q | ic_cancel;

  assign mem_arvalid = arvalid_q;
  assign mem_araddr  = addr_q;
  assign mem_arlen   = len_q;
  assign ic_gnt      = arvalid_q & mem_arready & ic_own;
  assign dc_gnt      = arvalid_q & mem_arready & ~ic_own;
  assign ic_rvalid   = beat & ic_own & ~ic_dropping;
  assign dc_rvalid   = beat & ~ic_own;
  assign resp_rdata  = beat ? mem_rdata : '0;
  assign resp_rlast  = beat & mem_rlast;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_IC;
      last_owner <= OWN_IC;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      arvalid_q  <= 1'b0;
      cancel_q   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cancel_q <= 1'b0;
          if (any_req) begin
            owner      <= winner;
            last_owner <= winner;
            addr_q     <= (winner == OWN_IC) ? ic_addr : dc_addr;
            len_q      <= (winner == OWN_IC) ? ic_len : dc_len;
            arvalid_q  <= 1'b1;
            state      <= ADDR;
          end
        end
        ADDR: begin
          // The address is never retracted; a flush here only marks the data to be dropped.
          if (ic_cancel && ic_own) begin
            cancel_q <= 1'b1;
          end
          if (mem_arready) begin
            arvalid_q <= 1'b0;
            beat_cnt  <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (mem_rvalid) begin
            beat_cnt  <= beat_cnt + 1'b1;
            proto_err <= proto_err | ((beat_cnt == len_q) && !mem_rlast);
          end
          if (mem_rvalid && mem_rlast) begin
            cancel_q <= 1'b0;
            beat_cnt <= '0;
            state    <= IDLE;
          end else if (ic_cancel && ic_own) begin
            cancel_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed and randomized bench for mem_read_arbiter with a bench-side memory model.
module tb_mem_read_arbiter;
  import mem_read_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_req, ic_cancel, dc_req;
  logic [31:0] ic_addr, dc_addr;
  logic [3:0]  ic_len, dc_len;
  logic        ic_gnt, ic_rvalid, dc_gnt, dc_rvalid;
  logic [31:0] resp_rdata;
  logic        resp_rlast;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic [3:0]  mem_arlen;
  logic        mem_arready, mem_rvalid, mem_rlast;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_read_arbiter #(.LEN_W(4)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_len(ic_len), .ic_cancel(ic_cancel),
    .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_len(dc_len),
    .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid),
    .resp_rdata(resp_rdata), .resp_rlast(resp_rlast),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen),
    .mem_arready(mem_arready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rlast(mem_rlast)
  );

  always #5 clk = ~clk;

  task automatic init_inputs();
    ic_req = 0; ic_cancel = 0; dc_req = 0;
    ic_addr = '0; dc_addr = '0; ic_len = '0; dc_len = '0;
    mem_arready = 0; mem_rvalid = 0; mem_rlast = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    init_inputs();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic last, input logic cancel);
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = d; mem_rlast = last; ic_cancel = cancel;
    #1;
  endtask

  task automatic mem_quiet();
    @(negedge clk);
    mem_rvalid = 0; mem_rlast = 0; mem_arready = 0; ic_cancel = 0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    init_inputs();
    ic_req = 1; dc_req = 1; mem_arready = 1; mem_rvalid = 1; mem_rlast = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({mem_arvalid, ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, resp_rlast} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000000",
               {mem_arvalid, ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, resp_rlast});
    end
    checks++;
    if (mem_araddr !== 32'h0 || mem_arlen !== 4'h0) begin
      errors++;
      $display("FAIL reset_addr got %h/%h exp 0/0", mem_araddr, mem_arlen);
    end
    @(negedge clk);
    reset = 0;
    init_inputs();
  endtask

  task automatic test_dc_burst();
    @(negedge clk);
    dc_req = 1; dc_addr = 32'h1FC0_0000; dc_len = 4'd3;
    #1;
    checks++;
    if (mem_arvalid !== 1'b0 || dc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL dc_idle arvalid/gnt got %b%b exp 00", mem_arvalid, dc_gnt);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h1FC0_0000 || mem_arlen !== 4'd3 || dc_gnt !== 1'b0) begin
        errors++;
        $display("FAIL dc_addr_wait%0d got v=%b a=%h l=%h g=%b exp 1 1fc00000 3 0",
                 i, mem_arvalid, mem_araddr, mem_arlen, dc_gnt);
      end
    end
    @(negedge clk);
    mem_arready = 1;
    #1;
    checks++;
    if (dc_gnt !== 1'b1 || ic_gnt !== 1'b0) begin
      errors++;
      $display("FAIL dc_gnt got dc=%b ic=%b exp 1 0", dc_gnt, ic_gnt);
    end
    @(negedge clk);
    mem_arready = 0; dc_req = 0;
    #1;
    checks++;
    if (dc_gnt !== 1'b0 || mem_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL dc_gnt_once got gnt=%b arvalid=%b exp 0 0", dc_gnt, mem_arvalid);
    end
    for (int b = 0; b < 4; b++) begin
      drive_beat(32'hD000_0000 + 32'(b), b == 3, 1'b0);
      checks++;
      if (dc_rvalid !== 1'b1 || ic_rvalid !== 1'b0 || resp_rdata !== 32'hD000_0000 + 32'(b) ||
          resp_rlast !== (b == 3)) begin
        errors++;
        $display("FAIL dc_beat%0d got dv=%b iv=%b d=%h l=%b exp 1 0 %h %b", b, dc_rvalid,
                 ic_rvalid, resp_rdata, resp_rlast, 32'hD000_0000 + 32'(b), b == 3);
      end
    end
    // Stray beat after the burst must be ignored in IDLE.
    drive_beat(32'hBAD0_BAD0, 1'b1, 1'b0);
    checks++;
    if (dc_rvalid !== 1'b0 || resp_rlast !== 1'b0 || mem_arvalid !== 1'b0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL dc_back_idle got dv=%b l=%b av=%b st=%0d exp 0 0 0 0",
               dc_rvalid, resp_rlast, mem_arvalid, dut.state);
    end
    mem_quiet();
  endtask

  task automatic test_tie();
    logic exp_dc;
    do_reset();
    @(negedge clk);
    ic_req = 1; ic_addr = 32'h0000_0100; ic_len = 0;
    dc_req = 1; dc_addr = 32'h0000_0200; dc_len = 0;
    for (int r = 0; r < 4; r++) begin
      exp_dc = (r % 2 == 0);
      @(negedge clk);
      mem_arready = 1;
      #1;
      checks++;
      if (dc_gnt !== exp_dc || ic_gnt !== !exp_dc ||
          mem_araddr !== (exp_dc ? 32'h0000_0200 : 32'h0000_0100)) begin
        errors++;
        $display("FAIL tie_gnt%0d got dc=%b ic=%b a=%h exp dc=%b", r, dc_gnt, ic_gnt, mem_araddr, exp_dc);
      end
      @(negedge clk);
      mem_arready = 0; mem_rvalid = 1; mem_rlast = 1; mem_rdata = 32'(r);
      #1;
      checks++;
      if (dc_rvalid !== exp_dc || ic_rvalid !== !exp_dc) begin
        errors++;
        $display("FAIL tie_rvalid%0d got dc=%b ic=%b exp dc=%b", r, dc_rvalid, ic_rvalid, exp_dc);
      end
      @(negedge clk);
      mem_rvalid = 0; mem_rlast = 0;
      if (r == 3) begin
        ic_req = 0; dc_req = 0;
      end
    end
  endtask

  task automatic test_ic_cancel_data();
    @(negedge clk);
    ic_req = 1; ic_addr = 32'h0000_1000; ic_len = 4'd7;
    @(negedge clk);
    mem_arready = 1;
    #1;
    checks++;
    if (ic_gnt !== 1'b1 || mem_arlen !== 4'd7) begin
      errors++;
      $display("FAIL icd_gnt got %b len %h exp 1 7", ic_gnt, mem_arlen);
    end
    @(negedge clk);
    mem_arready = 0; ic_req = 0; ic_len = 0;
    for (int b = 0; b < 2; b++) begin
      drive_beat(32'hA000_0000 + 32'(b), 1'b0, 1'b0);
      checks++;
      if (ic_rvalid !== 1'b1) begin
        errors++;
        $display("FAIL icd_beat%0d got %b exp 1", b, ic_rvalid);
      end
    end
    @(negedge clk);
    mem_rvalid = 0; ic_cancel = 1;
    for (int b = 2; b < 8; b++) begin
      drive_beat(32'hA000_0000 + 32'(b), b == 7, 1'b0);
      checks++;
      if (ic_rvalid !== 1'b0 || dc_rvalid !== 1'b0 || resp_rlast !== (b == 7)) begin
        errors++;
        $display("FAIL icd_drain%0d got iv=%b dv=%b l=%b exp 0 0 %b", b, ic_rvalid, dc_rvalid,
                 resp_rlast, b == 7);
      end
    end
    @(negedge clk);
    mem_rvalid = 0; mem_rlast = 0; ic_req = 1; ic_addr = 32'h0000_1100;
    @(negedge clk);
    mem_arready = 1;
    #1;
    checks++;
    if (ic_gnt !== 1'b1 || mem_araddr !== 32'h0000_1100) begin
      errors++;
      $display("FAIL icd_refetch got gnt=%b a=%h exp 1 00001100", ic_gnt, mem_araddr);
    end
    @(negedge clk);
    mem_arready = 0; ic_req = 0;
    drive_beat(32'h0000_C0DE, 1'b1, 1'b0);
    checks++;
    if (ic_rvalid !== 1'b1 || resp_rdata !== 32'h0000_C0DE) begin
      errors++;
      $display("FAIL icd_flag_clear got v=%b d=%h exp 1 0000c0de", ic_rvalid, resp_rdata);
    end
    mem_quiet();
  endtask

  task automatic test_ic_cancel_addr();
    @(negedge clk);
    ic_req = 1; ic_addr = 32'h2000_0040; ic_len = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ic_cancel = (i == 0);
      if (i == 1) begin
        dc_req = 1; dc_addr = 32'h3000_0000; dc_len = 0;
      end
      #1;
      checks++;
      if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h2000_0040 || mem_arlen !== 4'd1 || ic_gnt !== 1'b0) begin
        errors++;
        $display("FAIL ica_stable%0d got v=%b a=%h l=%h g=%b exp 1 20000040 1 0",
                 i, mem_arvalid, mem_araddr, mem_arlen, ic_gnt);
      end
    end
    @(negedge clk);
    ic_cancel = 0; mem_arready = 1;
    #1;
    checks++;
    if (ic_gnt !== 1'b1 || dc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL ica_gnt got ic=%b dc=%b exp 1 0", ic_gnt, dc_gnt);
    end
    @(negedge clk);
    mem_arready = 0; ic_req = 0;
    for (int b = 0; b < 2; b++) begin
      drive_beat(32'hE000_0000 + 32'(b), b == 1, 1'b0);
      checks++;
      if (ic_rvalid !== 1'b0 || dc_rvalid !== 1'b0 || resp_rlast !== (b == 1)) begin
        errors++;
        $display("FAIL ica_drain%0d got iv=%b dv=%b l=%b exp 0 0 %b", b, ic_rvalid, dc_rvalid,
                 resp_rlast, b == 1);
      end
    end
    @(negedge clk);
    mem_rvalid = 0; mem_rlast = 0;
    #1;
    checks++;
    if (mem_arvalid !== 1'b0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL ica_idle got av=%b st=%0d exp 0 0", mem_arvalid, dut.state);
    end
    @(negedge clk);
    mem_arready = 1;
    #1;
    checks++;
    if (dc_gnt !== 1'b1 || mem_araddr !== 32'h3000_0000) begin
      errors++;
      $display("FAIL ica_dc_next got g=%b a=%h exp 1 30000000", dc_gnt, mem_araddr);
    end
    @(negedge clk);
    mem_arready = 0; dc_req = 0;
    drive_beat(32'h0000_0D0D, 1'b1, 1'b1);
    checks++;
    if (dc_rvalid !== 1'b1 || ic_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL ica_dc_beat got dv=%b iv=%b exp 1 0", dc_rvalid, ic_rvalid);
    end
    mem_quiet();
  endtask

  task automatic test_cancel_idle();
    @(negedge clk);
    ic_cancel = 1; ic_req = 1; ic_addr = 32'h0000_4000; ic_len = 0;
    @(negedge clk);
    ic_cancel = 0; mem_arready = 1;
    #1;
    checks++;
    if (ic_gnt !== 1'b1 || mem_araddr !== 32'h0000_4000) begin
      errors++;
      $display("FAIL cidle_gnt got g=%b a=%h exp 1 00004000", ic_gnt, mem_araddr);
    end
    @(negedge clk);
    mem_arready = 0; ic_req = 0;
    drive_beat(32'h0000_4444, 1'b1, 1'b0);
    checks++;
    if (ic_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL cidle_beat got %b exp 1", ic_rvalid);
    end
    mem_quiet();
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    dc_req = 1; dc_addr = 32'h0000_6000; dc_len = 4'd3;
    @(negedge clk);
    mem_arready = 1;
    @(negedge clk);
    mem_arready = 0; dc_req = 0;
    drive_beat(32'h0000_0011, 1'b0, 1'b0);
    checks++;
    if (dc_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre got %b exp 1", dc_rvalid);
    end
    #1 reset = 1;
    #1;
    checks++;
    if ({mem_arvalid, ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, resp_rlast} !== 6'b0 ||
        mem_araddr !== 32'h0 || mem_arlen !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid_out got %b a=%h l=%h exp 000000 0 0",
               {mem_arvalid, ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, resp_rlast}, mem_araddr, mem_arlen);
    end
    checks++;
    if (dut.state !== IDLE || dut.last_owner !== OWN_IC) begin
      errors++;
      $display("FAIL rst_mid_state got st=%0d lo=%0d exp 0 0", dut.state, dut.last_owner);
    end
    @(negedge clk);
    reset = 0;
    init_inputs();
  endtask

  task automatic test_random();
    logic   ic_drop = 0, dc_drop = 0, in_burst = 0;
    owner_t cur = OWN_IC;
    int     beats_left = 0, exp_beats = 0, got = 0, bursts = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (ic_drop) begin ic_req = 0; ic_drop = 0; end
      if (dc_drop) begin dc_req = 0; dc_drop = 0; end
      if (cyc < 1700 && !ic_req && $urandom_range(0, 3) == 0) begin
        ic_req = 1; ic_addr = $urandom; ic_len = 4'($urandom_range(0, 15));
      end
      if (cyc < 1700 && !dc_req && $urandom_range(0, 3) == 0) begin
        dc_req = 1; dc_addr = $urandom; dc_len = 4'($urandom_range(0, 15));
      end
      mem_arready = ($urandom_range(0, 2) != 0);
      if (in_burst && beats_left > 0 && $urandom_range(0, 2) != 0) begin
        mem_rvalid = 1; mem_rdata = $urandom; mem_rlast = (beats_left == 1);
      end else begin
        mem_rvalid = 0; mem_rlast = 0;
      end
      #1;
      checks++;
      if ((ic_gnt && dc_gnt) || (ic_rvalid && dc_rvalid)) begin
        errors++;
        $display("FAIL rnd_mutex cyc %0d got gnt=%b%b rv=%b%b exp no pair", cyc, ic_gnt, dc_gnt,
                 ic_rvalid, dc_rvalid);
      end
      if (mem_rvalid) begin
        checks++;
        if (resp_rdata !== mem_rdata) begin
          errors++;
          $display("FAIL rnd_data cyc %0d got %h exp %h", cyc, resp_rdata, mem_rdata);
        end
        got += (cur == OWN_IC) ? int'(ic_rvalid) : int'(dc_rvalid);
        beats_left--;
        if (mem_rlast) begin
          checks++;
          if (got != exp_beats) begin
            errors++;
            $display("FAIL rnd_beats burst %0d got %0d exp %0d", bursts, got, exp_beats);
          end
          in_burst = 0;
          bursts++;
        end
      end
      if (ic_gnt || dc_gnt) begin
        cur = ic_gnt ? OWN_IC : OWN_DC;
        checks++;
        if (mem_araddr !== (ic_gnt ? ic_addr : dc_addr) || mem_arlen !== (ic_gnt ? ic_len : dc_len)) begin
          errors++;
          $display("FAIL rnd_ar cyc %0d got %h/%h exp %h/%h", cyc, mem_araddr, mem_arlen,
                   ic_gnt ? ic_addr : dc_addr, ic_gnt ? ic_len : dc_len);
        end
        exp_beats  = int'(ic_gnt ? ic_len : dc_len) + 1;
        beats_left = exp_beats;
        got        = 0;
        in_burst   = 1;
        if (ic_gnt) ic_drop = 1;
        else dc_drop = 1;
      end
    end
    checks++;
    if (in_burst || bursts < 20 || dut.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL rnd_end got open=%b bursts=%0d perr=%b exp 0 >=20 0", in_burst, bursts, dut.proto_err);
    end
    mem_quiet();
  endtask

  initial begin
    test_reset();
    test_dc_burst();
    test_tie();
    test_ic_cancel_data();
    test_ic_cancel_addr();
    test_cancel_idle();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter LEN_W, default 4: burst-length field width; beats = len+1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ic_req  input  1  icache refill request; held with ic_addr/ic_len until ic_gnt.
REQ-005 ic_addr  input  32  icache refill physical address.
REQ-006 ic_len  input  LEN_W  icache burst length minus one.
REQ-007 ic_cancel  input  1  pipeline flush: icache drops its outstanding refill.
REQ-008 ic_gnt  output  1  icache request accepted by memory this cycle.
REQ-009 ic_rvalid  output  1  read beat for icache.
REQ-010 dc_req  input  1  dcache/uncached read request; same hold rule as ic_req.
REQ-011 dc_addr  input  32  dcache physical address.
REQ-012 dc_len  input  LEN_W  dcache burst length minus one.
REQ-013 dc_gnt  output  1  dcache request accepted by memory this cycle.
REQ-014 dc_rvalid  output  1  read beat for dcache.
REQ-015 resp_rdata  output  32  beat data, shared by both requesters.
REQ-016 resp_rlast  output  1  final beat of current burst.
REQ-017 mem_arvalid  output  1  address valid to memory port.
REQ-018 mem_araddr  output  32  address to memory port.
REQ-019 mem_arlen  output  LEN_W  burst length to memory port.
REQ-020 mem_arready  input  1  memory accepts address.
REQ-021 mem_rvalid  input  1  memory beat valid; mem_rready tied 1 (requesters always sink).
REQ-022 mem_rdata  input  32  memory beat data.
REQ-023 mem_rlast  input  1  memory last beat.

Function
REQ-024 FSM states IDLE, ADDR, DATA; one burst outstanding at a time.
REQ-025 IDLE: if any req, latch winner's addr/len into registers, record owner, go ADDR next cycle.
REQ-026 Arbitration round-robin: on simultaneous ic_req and dc_req, grant the requester not served last; last_owner resets to icache (dcache wins first tie).
REQ-027 ADDR: mem_arvalid=1 with latched addr/len; when mem_arready, assert owner's gnt that cycle, go DATA.
REQ-028 mem_araddr/mem_arlen SHALL stay stable while mem_arvalid=1 and mem_arready=0.
REQ-029 DATA: each mem_rvalid forwards combinationally: resp_rdata=mem_rdata, resp_rlast=mem_rlast, owner's rvalid=1; latency 0 cycles.
REQ-030 DATA: beat counter increments per beat; on mem_rlast go IDLE; new arbitration no earlier than next cycle.
REQ-031 Beat counter reaching len without mem_rlast SHALL set sticky protocol-error flag (verification observable, no output).
REQ-032 ic_cancel in ADDR with icache owner: address still issued (no retraction); cancel flag set.
REQ-033 ic_cancel in DATA with icache owner, or cancel flag set: remaining beats drained with ic_rvalid=0; flag clears on mem_rlast.
REQ-034 ic_cancel in IDLE, or while dcache owns: no effect.
REQ-035 ic_cancel and ic_req same cycle in IDLE: request arbitrated normally (new fetch after flush).
REQ-036 ic_gnt and dc_gnt SHALL never both be 1; ic_rvalid and dc_rvalid never both 1.
REQ-037 mem_rvalid in IDLE or ADDR SHALL be ignored (no rvalid to either requester).

Reset
REQ-038 Reset: state=IDLE, last_owner=icache, cancel flag=0, beat counter=0, error flag=0.
REQ-039 During/after reset all outputs 0: mem_arvalid, ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, resp_rlast; mem_araddr/arlen=0.
REQ-040 Reset mid-burst abandons burst; memory side assumed reset together.

Structure
REQ-041 State enum and burst-length typedef in shared cpu package header; address uses existing phys_t, data uint32_t.
REQ-042 Single module; round-robin picker may be a sub-module rr_arb2 (2-input, last-owner input).

Verification
REQ-043 dc_req only, addr 0x1FC0_0000 len 3, arready after 2 cycles -> dc_gnt one cycle, 4 dc_rvalid beats, resp_rlast on 4th, IDLE after.
REQ-044 ic_req and dc_req same cycle from reset -> dcache first; next tie -> icache; grants alternate.
REQ-045 icache burst len 7, ic_cancel after beat 2 -> beats 3-8 drained, ic_rvalid=0, next ic_req granted after rlast.
REQ-046 ic_cancel during ADDR, arready held low 5 cycles -> address stable, zero ic_rvalid, FSM back to IDLE at rlast.
REQ-047 async reset asserted in DATA mid-beat -> all outputs 0 immediately, IDLE, last_owner=icache.
REQ-048 random back-to-back traffic with random arready/rvalid -> gnt/rvalid mutual exclusion, per-requester beat counts = len+1.
